// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, one-cycle-latency imem reads and a 2-entry
// instruction FIFO feeding the execute core over a valid/ready handshake.
module instr_fetch #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            halt,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            ir_valid,
    input  logic            ir_ready,
    output logic [31:0]     ir_data,
    output logic [PC_W-1:0] ir_pc,
    output logic [15:0]     fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] addr_q;
    logic            inflight_q;
    logic [31:0]     data_q [2];
    logic [PC_W-1:0] epc_q  [2];
    logic            rd_q;
    logic            wr_q;
    logic [1:0]      cnt_q;
    logic [1:0]      cnt_d;
    logic [15:0]     fcnt_q;

    logic            pop_raw;
    logic            pop;
    logic            push;
    logic            issue;
    logic [2:0]      level;
    logic [2:0]      limit;

    // Handshake, return and issue decisions for the current cycle
    always_comb begin
        pop_raw = (cnt_q != 2'd0) & ir_ready;
        pop     = pop_raw & ~redirect_valid;
        push    = inflight_q & ~redirect_valid;
        // Words already owed to the FIFO plus its contents, minus what leaves now
        level   = {1'b0, cnt_q} + {2'b00, inflight_q};
        limit   = 3'd2 + {2'b00, pop_raw};
        issue   = (state_q == S_RUN) & ~halt & ~redirect_valid
                & (level < limit);
    end

    assign imem_en     = issue;
    assign imem_addr   = issue ? pc_q : addr_q;
    assign ir_valid    = (cnt_q != 2'd0);
    assign ir_data     = data_q[rd_q];
    assign ir_pc       = epc_q[rd_q];
    assign fetch_count = fcnt_q;

    // Run-control FSM; a redirect never changes the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else if (!redirect_valid) begin
            unique case (state_q)
                S_IDLE:  if (start) state_q <= S_RUN;
                S_RUN:   if (halt) state_q <= S_HALT;
                S_HALT:  if (start && !halt) state_q <= S_RUN;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Program counter and last issued address (doubles as the return tag)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            addr_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q   <= redirect_pc;
        end else if (issue) begin
            pc_q   <= pc_q + PC_W'(1);
            addr_q <= pc_q;
        end
    end

    // A read is owed next cycle only if it was issued; redirect squashes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
        end
    end

    // FIFO occupancy update for simultaneous push/pop
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    // Instruction FIFO storage and pointers, flushed on redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                epc_q[i]  <= '0;
            end
        end else if (redirect_valid) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push) begin
                data_q[wr_q] <= imem_rdata;
                epc_q[wr_q]  <= addr_q;
                wr_q         <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_d;
        end
    end

    // Delivered-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= '0;
        end else if (pop) begin
            fcnt_q <= fcnt_q + 16'd1;
        end
    end

endmodule
